// File: rtl/jtag_chan_bank.sv
// jtag_chan_bank: serial JTAG data-register to NUM_CH parallel channel bridge.
// A frame {WR, ADDR, DATA} is shifted in LSB first; update writes the addressed
// channel (WR=1) and always selects that channel for the next capture.
module jtag_chan_bank #(
  parameter int NUM_CH  = 15,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int RB_MODE = 0
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iTDI,
  input  logic                     iSHIFT,
  input  logic                     iCAPTURE,
  input  logic                     iUPDATE,
  output logic                     oTDO,
  input  logic [NUM_CH*DATA_W-1:0] iREAD,
  output logic [NUM_CH*DATA_W-1:0] oWRITE,
  output logic [NUM_CH-1:0]        oWRITE_STB,
  output logic                     oERR
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int AXW     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  // Channel count widened by one bit so NUM_CH == 2**ADDR_W still compares correctly.
  localparam logic [AXW-1:0]   NUM_CH_X = AXW'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_SHFT = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [FRAME_W-1:0]         sr_q, sr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          sel_q, sel_d;
  logic [NUM_CH*DATA_W-1:0]   write_q, write_d;
  logic [NUM_CH-1:0]          stb_q, stb_d;
  logic                       err_q, err_d;

  logic                       f_wr;
  logic [ADDR_W-1:0]          f_addr;
  logic [DATA_W-1:0]          f_data;
  logic                       addr_ok;
  logic                       frame_ok;
  logic                       conflict;
  logic [DATA_W-1:0]          rb_word;

  // Decode the shifted frame, detect strobe collisions and pick the readback word.
  always_comb begin
    f_data   = sr_q[DATA_W-1:0];
    f_addr   = sr_q[DATA_W +: ADDR_W];
    f_wr     = sr_q[FRAME_W-1];
    addr_ok  = ({1'b0, f_addr} < NUM_CH_X);
    frame_ok = (cnt_q == CNT_FULL) && !(f_wr && !addr_ok);
    conflict = (iUPDATE & iCAPTURE) | (iUPDATE & iSHIFT) | (iCAPTURE & iSHIFT);
    // An out-of-range selection matches no channel and reads back as zero.
    rb_word  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == ADDR_W'(k)) begin
        if (RB_MODE != 0) rb_word = write_q[k*DATA_W +: DATA_W];
        else              rb_word = iREAD[k*DATA_W +: DATA_W];
      end
    end
  end

  // Tap-style state tracking; strobe priority is UPDATE > CAPTURE > SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iCAPTURE && !iUPDATE) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (iUPDATE)       state_d = S_UPD;
        else if (iCAPTURE) state_d = S_CAPT;
        else if (iSHIFT)   state_d = S_SHFT;
        else               state_d = S_IDLE;
      end
      S_SHFT: begin
        if (iUPDATE)       state_d = S_UPD;
        else if (iCAPTURE) state_d = S_CAPT;
        else               state_d = S_SHFT;
      end
      S_UPD: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture / shift / update actions; the strobe vector is a one-cycle pulse.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    write_d = write_q;
    stb_d   = '0;
    err_d   = err_q;
    if (iUPDATE) begin
      if (frame_ok) begin
        sel_d = f_addr;
        if (f_wr) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (f_addr == ADDR_W'(k)) begin
              write_d[k*DATA_W +: DATA_W] = f_data;
              stb_d[k]                    = 1'b1;
            end
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (iCAPTURE) begin
      // Error is reported in the captured frame once, then cleared.
      sr_d  = {err_q, sel_q, rb_word};
      cnt_d = '0;
      err_d = 1'b0;
    end else if (iSHIFT) begin
      sr_d = {iTDI, sr_q[FRAME_W-1:1]};
      // Saturating one past a full frame keeps over-long frames invalid.
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
    if (conflict) err_d = 1'b1;
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      write_q <= '0;
      stb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign oTDO       = sr_q[0];
  assign oWRITE     = write_q;
  assign oWRITE_STB = stb_q;
  assign oERR       = err_q;

endmodule
